mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; ports are listed below, clock and reset first.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rstn  in  1  asynchronous, active-low reset.
REQ-004 A  in  32  rs operand from the EX stage, the same operand the ALU receives.
REQ-005 B  in  32  rt operand from the EX stage.
REQ-006 MDUOp  in  3  operation: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, 6-7 reserved/no-op.
REQ-007 start  in  1  request; sampled on a rising clk edge.
REQ-008 cancel  in  1  pipeline flush; aborts any operation in flight.
REQ-009 busy  out  1  high while a multiply or divide is iterating; the pipeline stalls on it.
REQ-010 done  out  1  one-cycle pulse when HI/LO are updated by a multiply or divide.
REQ-011 HI  out  32  HI register (read by MFHI).
REQ-012 LO  out  32  LO register (read by MFLO).

Function
REQ-013 Acceptance SHALL occur on a rising edge with start=1, busy=0 and cancel=0; in any other case start is ignored.
REQ-014 MTHI/MTLO accepted at edge T SHALL write A into HI/LO at T, leave busy at 0 and produce no done.
REQ-015 On acceptance, a multiply or divide SHALL latch |A| and |B| (signed ops) or A and B (unsigned ops), latch the sign fix-up flags, and set busy=1 at T0.
REQ-016 The datapath SHALL be iterative: one shift-add step (multiply) or one restoring shift-subtract step (divide) per clock, 32 steps, with the step counter counting 0 to 31.
REQ-017 At edge T32 the block SHALL write HI/LO, clear busy and assert done for exactly the cycle after T32; busy is high for exactly 32 cycles.
REQ-018 Multiply results SHALL be the 64-bit product, with {HI,LO} = product; for MULT the result is negated when exactly one operand is negative.
REQ-019 Divide results SHALL be LO = quotient and HI = remainder; for DIV the quotient is negated if the operand signs differ and the remainder takes the sign of A.
REQ-020 For DIV, 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-021 Divide by zero SHALL finish with normal latency and give HI=A and LO=0xFFFFFFFF (the unsigned restoring-divider result, also applied to DIV); no trap.
REQ-022 cancel=1 at any edge SHALL clear busy and the counter at that edge, leave HI/LO unchanged, produce no done, and win over a simultaneous start.
REQ-023 While busy=1, start (including MTHI/MTLO) SHALL be ignored and HI/LO SHALL hold their previous values until T32.
REQ-024 HI/LO SHALL be stable, registered outputs; partial products SHALL never appear on them.
REQ-025 Reserved MDUOp values with start=1 SHALL cause no state change.

Reset
REQ-026 rstn=0 SHALL immediately force HI=0, LO=0, busy=0, done=0, counter=0 and clear the internal operands, including mid-operation.
REQ-027 After rstn is released, the first accepted start SHALL behave as from idle.

Configuration
REQ-028 Macro MDU_DIV_EN, when defined, SHALL compile in the divider datapath and DIVU/DIV.
REQ-029 Without MDU_DIV_EN, DIVU/DIV SHALL be treated as reserved (REQ-025): busy stays 0, no done, HI/LO unchanged; multiply and move behaviour is identical in both builds.

Verification
REQ-030 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> busy for 32 cycles, done pulse, HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-032 DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=100, B=0 -> HI=100, LO=0xFFFFFFFF (MDU_DIV_EN defined).
REQ-033 MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 -> HI=0x12345678, LO=0x9ABCDEF0, busy never asserted.
REQ-034 MULTU started, cancel at iteration 10, then MTLO during the busy window of a second MULTU -> HI/LO keep their prior values, no done after the cancel, the MTLO is ignored.
REQ-035 rstn pulsed low at iteration 20 of a DIVU -> all outputs 0 asynchronously, no done; without MDU_DIV_EN, DIVU start -> busy=0 and HI/LO unchanged.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-step multiply/divide unit holding the HI/LO registers.
// Define MDU_DIV_EN to build the divider datapath and enable DIVU/DIV.
module mul_div_unit (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDUOp,
    input  logic        start,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] opd;
    logic        neg_main;
    logic        accept;
    logic        go_mul;
    logic        go_div;
    logic        op_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        last;
    logic [32:0] mul_sum;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic [63:0] prod;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
`ifdef MDU_DIV_EN
    logic        is_div;
    logic        neg_rem;
    logic [32:0] div_rem;
    logic        div_ge;
    logic [31:0] div_dif;
`endif

    assign busy   = (state == S_RUN);
    assign accept = start & ~busy & ~cancel;
    assign last   = (cnt == 5'd31);

    // Decode the request and form operand magnitudes for signed ops.
    always_comb begin
        op_signed = MDUOp[0];
        go_mul    = accept & ((MDUOp == OP_MULTU) | (MDUOp == OP_MULT));
`ifdef MDU_DIV_EN
        go_div    = accept & ((MDUOp == OP_DIVU) | (MDUOp == OP_DIV));
`else
        go_div    = 1'b0;
`endif
        abs_a = (op_signed & A[31]) ? (32'd0 - A) : A;
        abs_b = (op_signed & B[31]) ? (32'd0 - B) : B;
    end

    // One iteration step plus the sign fix-up applied on the last step.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : 33'd0);
        step_hi = mul_sum[32:1];
        step_lo = {mul_sum[0], acc_lo[31:1]};
        prod    = {step_hi, step_lo};
        if (neg_main) begin
            prod = 64'd0 - prod;
        end
        res_hi = prod[63:32];
        res_lo = prod[31:0];
`ifdef MDU_DIV_EN
        div_rem = {acc_hi, acc_lo[31]};
        div_ge  = (div_rem >= {1'b0, opd});
        div_dif = div_rem[31:0] - opd;
        if (is_div) begin
            step_hi = div_ge ? div_dif : div_rem[31:0];
            step_lo = {acc_lo[30:0], div_ge};
            res_hi  = neg_rem ? (32'd0 - step_hi) : step_hi;
            res_lo  = neg_main ? (32'd0 - step_lo) : step_lo;
        end
`endif
    end

    // Control state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: run for 32 steps, flush on cancel.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (go_mul | go_div) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (cancel | last) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand latch, iteration registers, HI/LO and done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= 5'd0;
            acc_hi   <= 32'd0;
            acc_lo   <= 32'd0;
            opd      <= 32'd0;
            neg_main <= 1'b0;
            HI       <= 32'd0;
            LO       <= 32'd0;
            done     <= 1'b0;
`ifdef MDU_DIV_EN
            is_div   <= 1'b0;
            neg_rem  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (cancel) begin
                cnt <= 5'd0;
            end else if (busy) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= cnt + 5'd1;
                if (last) begin
                    HI   <= res_hi;
                    LO   <= res_lo;
                    done <= 1'b1;
                end
            end else if (go_mul) begin
                cnt      <= 5'd0;
                acc_hi   <= 32'd0;
                acc_lo   <= abs_b;
                opd      <= abs_a;
                neg_main <= op_signed & (A[31] ^ B[31]);
`ifdef MDU_DIV_EN
                is_div   <= 1'b0;
                neg_rem  <= 1'b0;
            end else if (go_div) begin
                cnt      <= 5'd0;
                acc_hi   <= 32'd0;
                acc_lo   <= abs_a;
                opd      <= abs_b;
                is_div   <= 1'b1;
                neg_main <= op_signed & (A[31] ^ B[31]) & (B != 32'd0);
                neg_rem  <= op_signed & A[31];
`endif
            end else if (accept && MDUOp == OP_MTHI) begin
                HI <= A;
            end else if (accept && MDUOp == OP_MTLO) begin
                LO <= A;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed checks of mul_div_unit against an arithmetic model.
module tb_mul_div_unit;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDUOp;
    logic        start;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    mul_div_unit dut (
        .clk    (clk),
        .rstn   (rstn),
        .A      (A),
        .B      (B),
        .MDUOp  (MDUOp),
        .start  (start),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_md(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            3'd0: return {32'd0, a} * {32'd0, b};
            3'd1: return sa * sb;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF)
                    return {32'd0, 32'h80000000};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        bit          iter;
        int          cyc;
        logic [63:0] r;
        iter = (op <= 3'd1) || (DIV_EN && (op == 3'd2 || op == 3'd3));
        @(negedge clk);
        A = a;
        B = b;
        MDUOp = op;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (iter) begin
            r = ref_md(op, a, b);
            mhi = r[63:32];
            mlo = r[31:0];
            cyc = 0;
            while (busy && cyc < 40) begin
                cyc++;
                @(negedge clk);
            end
            check($sformatf("busy_len op%0d", op), 64'(cyc), 64'd32);
            check($sformatf("done op%0d", op), {63'd0, done}, 64'd1);
            check($sformatf("HI op%0d a=%h b=%h", op, a, b), {32'd0, HI},
                  {32'd0, mhi});
            check($sformatf("LO op%0d a=%h b=%h", op, a, b), {32'd0, LO},
                  {32'd0, mlo});
            @(negedge clk);
            check("done_pulse_end", {63'd0, done}, 64'd0);
        end else begin
            if (op == 3'd4) mhi = a;
            if (op == 3'd5) mlo = a;
            check($sformatf("noiter_busy op%0d", op), {63'd0, busy}, 64'd0);
            check($sformatf("noiter_done op%0d", op), {63'd0, done}, 64'd0);
            check($sformatf("noiter_HI op%0d", op), {32'd0, HI}, {32'd0, mhi});
            check($sformatf("noiter_LO op%0d", op), {32'd0, LO}, {32'd0, mlo});
            @(negedge clk);
            check("noiter_busy2", {63'd0, busy}, 64'd0);
        end
    endtask

    function automatic logic [31:0] pick(input int unsigned sel);
        case (sel)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit          seen;
        int          cyc;
        logic [31:0] ca;
        logic [31:0] cb;
        logic [63:0] r;
        rstn = 1'b0;
        A = 32'd0;
        B = 32'd0;
        MDUOp = 3'd0;
        start = 1'b0;
        cancel = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_HI", {32'd0, HI}, 64'd0);
        check("rst_LO", {32'd0, LO}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        rstn = 1'b1;

        run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(3'd1, 32'hFFFFFFFD, 32'd7);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2);
        run_op(3'd2, 32'd100, 32'd0);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
        run_op(3'd3, 32'hFFFFFFF9, 32'd0);
        run_op(3'd4, 32'h12345678, 32'd0);
        run_op(3'd5, 32'h9ABCDEF0, 32'd0);
        run_op(3'd6, 32'h11111111, 32'd3);
        run_op(3'd7, 32'h22222222, 32'd5);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick($urandom_range(0, 7)),
                   pick($urandom_range(0, 7)));
        end

        @(negedge clk);
        A = 32'hDEADBEEF;
        B = 32'h1234;
        MDUOp = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {63'd0, busy}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("cancel_no_done", {63'd0, seen}, 64'd0);
        check("cancel_HI", {32'd0, HI}, {32'd0, mhi});
        check("cancel_LO", {32'd0, LO}, {32'd0, mlo});

        ca = $urandom;
        cb = $urandom;
        A = ca;
        B = cb;
        MDUOp = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        MDUOp = 3'd5;
        A = 32'hA5A5A5A5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_hold_LO", {32'd0, LO}, {32'd0, mlo});
        r = ref_md(3'd0, ca, cb);
        mhi = r[63:32];
        mlo = r[31:0];
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check("mtlo_busy_done", {63'd0, done}, 64'd1);
        check("mtlo_busy_HI", {32'd0, HI}, {32'd0, mhi});
        check("mtlo_busy_LO", {32'd0, LO}, {32'd0, mlo});

        @(negedge clk);
        MDUOp = 3'd4;
        A = 32'h0BADF00D;
        start = 1'b1;
        cancel = 1'b1;
        @(negedge clk);
        MDUOp = 3'd0;
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b0;
        check("cancel_start_HI", {32'd0, HI}, {32'd0, mhi});
        check("cancel_start_busy", {63'd0, busy}, 64'd0);

        @(negedge clk);
        A = 32'hFFFF0000;
        B = 32'd77;
        MDUOp = DIV_EN ? 3'd2 : 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("arst_HI", {32'd0, HI}, 64'd0);
        check("arst_LO", {32'd0, LO}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        mhi = 32'd0;
        mlo = 32'd0;
        @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("arst_no_done", {63'd0, seen}, 64'd0);

        run_op(3'd2, 32'd1000, 32'd7);
        run_op(3'd1, 32'h80000000, 32'h80000000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
